regbank_reader: RTL and testbench

//   Read-side companion of the 8-bit enable-written register: fetches one byte from a bank of

---
 rtl/regbank_reader.sv | 104 ++++++++++
 tb/tb_regbank_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regbank_reader.sv
// Single-outstanding read port onto a bank of DATA_W-bit registers.
// Returns the sampled byte over a valid/ready response channel.
module regbank_reader #(
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_W-1:0]          resp_data,
    output logic                       resp_err,
    output logic                       busy,
    output logic [7:0]                 rd_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [7:0]          rdcnt_q, rdcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rdcnt_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            rdcnt_q <= rdcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        rdcnt_d = rdcnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Out-of-range addresses fall through with zero data and err set
                    data_d = '0;
                    err_d  = 1'b1;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == i[ADDR_W-1:0]) begin
                            data_d = regs_flat[i*DATA_W +: DATA_W];
                            err_d  = 1'b0;
                        end
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rdcnt_d = rdcnt_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign rd_count   = rdcnt_q;

endmodule

// File: tb/tb_regbank_reader.sv
// Directed bench for regbank_reader: a 6-register/latency-1 instance
// and an 8-register/latency-4 instance sharing clock and reset.
module tb_regbank_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid_a, req_ready_a, resp_valid_a, resp_ready_a;
    logic [2:0]  req_addr_a;
    logic [47:0] regs_a;
    logic [7:0]  resp_data_a, rd_count_a;
    logic        resp_err_a, busy_a;

    logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b;
    logic [2:0]  req_addr_b;
    logic [63:0] regs_b;
    logic [7:0]  resp_data_b, rd_count_b;
    logic        resp_err_b, busy_b;

    int checks = 0;
    int errors = 0;

    regbank_reader #(
        .NUM_REGS(6), .ADDR_W(3), .DATA_W(8), .READ_LATENCY(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_addr(req_addr_a), .regs_flat(regs_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_data(resp_data_a), .resp_err(resp_err_a),
        .busy(busy_a), .rd_count(rd_count_a)
    );

    regbank_reader #(
        .NUM_REGS(8), .ADDR_W(3), .DATA_W(8), .READ_LATENCY(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr_b), .regs_flat(regs_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_data(resp_data_b), .resp_err(resp_err_b),
        .busy(busy_b), .rd_count(rd_count_b)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        req_valid_a = 0; req_addr_a = 0; resp_ready_a = 0;
        regs_a = 48'h0;
        req_valid_b = 0; req_addr_b = 0; resp_ready_b = 0;
        regs_b = 64'h0807_0605_0403_0201;

        #3;
        check("rst_ready", req_ready_a, 1);
        check("rst_valid", resp_valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_data", resp_data_a, 0);
        check("rst_cnt", rd_count_a, 0);
        #9 rst_n = 1;

        // 1) basic read of reg3
        regs_a[31:24] = 8'hA5;
        req_valid_a = 1; req_addr_a = 3; resp_ready_a = 1;
        tick();
        req_valid_a = 0; req_addr_a = 'x;
        check("t1_busy", busy_a, 1);
        check("t1_ready_low", req_ready_a, 0);
        check("t1_no_valid", resp_valid_a, 0);
        tick();
        check("t1_valid", resp_valid_a, 1);
        check("t1_data", resp_data_a, 8'hA5);
        check("t1_err", resp_err_a, 0);
        tick();
        check("t1_done", resp_valid_a, 0);
        check("t1_cnt", rd_count_a, 1);
        check("t1_idle", req_ready_a, 1);
        check("t1_hold", resp_data_a, 8'hA5);

        // 2) backpressure, bank change during RESP
        resp_ready_a = 0;
        req_valid_a = 1; req_addr_a = 3;
        tick();
        req_valid_a = 0;
        tick();
        regs_a[31:24] = 8'h11;
        tick(5);
        check("t2_valid", resp_valid_a, 1);
        check("t2_data", resp_data_a, 8'hA5);
        check("t2_cnt", rd_count_a, 1);
        resp_ready_a = 1;
        tick();
        check("t2_done", resp_valid_a, 0);
        check("t2_cnt2", rd_count_a, 2);

        // 3) out of range then in range
        regs_a[47:40] = 8'h5C;
        req_valid_a = 1; req_addr_a = 7;
        tick();
        req_valid_a = 0;
        tick();
        check("t3_oor_data", resp_data_a, 0);
        check("t3_oor_err", resp_err_a, 1);
        tick();
        check("t3_cnt", rd_count_a, 3);
        check("t3_err_hold", resp_err_a, 1);
        req_valid_a = 1; req_addr_a = 5;
        tick();
        req_valid_a = 0;
        tick();
        check("t3_ok_data", resp_data_a, 8'h5C);
        check("t3_ok_err", resp_err_a, 0);
        tick();
        check("t3_cnt2", rd_count_a, 4);

        // 4) 257 back-to-back reads, count wraps to 1
        rst_n = 0;
        #2;
        check("t4_rst_cnt", rd_count_a, 0);
        rst_n = 1;
        req_valid_a = 1; req_addr_a = 2; resp_ready_a = 1;
        bad = 0;
        for (int k = 1; k <= 257 * 3; k++) begin
            tick();
            if (req_ready_a !== ((k % 3) == 0)) bad++;
        end
        req_valid_a = 0;
        check("t4_pattern", bad, 0);
        check("t4_cnt", rd_count_a, 1);
        check("t4_idle", req_ready_a, 1);

        // 5) reset in WAIT and in RESP
        resp_ready_a = 0;
        req_valid_a = 1; req_addr_a = 3;
        tick();
        req_valid_a = 0;
        check("t5_wait", busy_a, 1);
        #2 rst_n = 0;
        #1;
        check("t5w_busy", busy_a, 0);
        check("t5w_ready", req_ready_a, 1);
        check("t5w_cnt", rd_count_a, 0);
        rst_n = 1;
        tick();
        check("t5w_noresp", resp_valid_a, 0);
        check("t5w_ready2", req_ready_a, 1);
        req_valid_a = 1;
        tick();
        req_valid_a = 0;
        tick();
        check("t5r_valid", resp_valid_a, 1);
        check("t5r_data", resp_data_a, 8'h11);
        rst_n = 0;
        #1;
        check("t5r_valid0", resp_valid_a, 0);
        check("t5r_data0", resp_data_a, 0);
        check("t5r_err0", resp_err_a, 0);
        rst_n = 1;
        tick();
        check("t5r_noresp", resp_valid_a, 0);
        check("t5r_ready", req_ready_a, 1);
        check("t5r_cnt", rd_count_a, 0);

        // 6) latency 4, bank change before the sample edge
        req_valid_b = 1; req_addr_b = 0; resp_ready_b = 1;
        tick();
        req_valid_b = 0;
        tick();
        check("t6_busy", busy_b, 1);
        tick();
        regs_b[7:0] = 8'h77;
        tick();
        check("t6_not_yet", resp_valid_b, 0);
        tick();
        check("t6_valid", resp_valid_b, 1);
        check("t6_data", resp_data_b, 8'h77);
        check("t6_err", resp_err_b, 0);
        tick();
        check("t6_done", resp_valid_b, 0);
        check("t6_cnt", rd_count_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
